fp_reg_file_p: RTL and testbench
================================

# fp_reg_file_p

Parametrised floating-point register file with single- and double-width (register pair) writes and four read outputs: two operands, each with its low and high pair word. Adds three things a plain register file lacks: same-cycle write-to-read bypass, a per-register pending-write scoreboard for load/long-latency hazard detection, and a sequenced clear sweep. Sits in the decode stage of the FP datapath, between the FP issue logic and the FP writeback mux.

## Interface
- DATA_W, 32, width of one register
- ADDR_W, 5, address width; NUM_REGS = 2^ADDR_W
- ZERO_PROT, 1, when 1 register 0 is never written (reads 0 forever)
- BYPASS, 1, when 1 read outputs forward same-cycle write data and busy-clear
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr1, rd_addr2  in  ADDR_W  operand read addresses
- rd_data1, rd_data2  out  DATA_W  contents of reg[rd_addrN]
- rd_data1_hi, rd_data2_hi  out  DATA_W  contents of reg[rd_addrN+1 mod NUM_REGS]
- rd_busy1, rd_busy2  out  1  pending bit of reg[rd_addrN]
- rd_busy1_hi, rd_busy2_hi  out  1  pending bit of reg[rd_addrN+1 mod NUM_REGS]
- wr_en  in  1  write request
- wr_dbl  in  1  with wr_en: pair write of wr_addr and wr_addr+1
- wr_addr  in  ADDR_W  write address
- wr_data_lo, wr_data_hi  in  DATA_W  data for wr_addr / wr_addr+1
- bs_en  in  1  mark destination pending (instruction issued)
- bs_dbl  in  1  with bs_en: mark bs_addr and bs_addr+1
- bs_addr  in  ADDR_W  scoreboard set address
- clr_req  in  1  start clear sweep (pulse)
- clr_active  out  1  sweep in progress
- wr_drop  out  1  registered pulse: a write or bs_en was discarded

## Operation
- Reset (rst_n=0, async): all registers 0, all busy bits 0, FSM IDLE, clr_active=0, wr_drop=0; read outputs therefore 0.
- Single write (wr_en=1, wr_dbl=0): reg[wr_addr] <= wr_data_lo; busy[wr_addr] <= 0. Suppressed if ZERO_PROT and wr_addr=0.
- Pair write (wr_en=1, wr_dbl=1): reg[a] <= lo, reg[a+1] <= hi, both busy cleared. Illegal if a = NUM_REGS-1, or if ZERO_PROT and a = 0: whole write discarded (no partial write), wr_drop pulses.
- Scoreboard set: bs_en sets busy[bs_addr] (and busy[bs_addr+1] if bs_dbl). The same legality rules as writes apply; illegal set is discarded with wr_drop. With ZERO_PROT, reg 0 is never marked busy.
- Same-cycle set and clear of one register: set wins (busy=1 after edge).
- Reads are combinational from the array. If BYPASS=1 and a legal write this cycle targets the read address (lo or hi port, either operand), rd_data returns the write data and rd_busy returns the post-edge value (0 unless bs_en also targets it).
- Hi read address wraps: rd_addr = NUM_REGS-1 gives hi from reg 0.
- Clear FSM: IDLE --clr_req--> SWEEP (ptr=0). In SWEEP, each cycle writes reg[ptr]=0, busy[ptr]=0, ptr++. After ptr = NUM_REGS-1 the FSM returns to IDLE.
- During SWEEP, wr_en and bs_en are discarded and pulse wr_drop. clr_req in SWEEP is ignored. Bypass is inactive for sweep writes.

## Timing
- Write latency: array visible 1 cycle after the edge; 0 cycles through bypass when BYPASS=1.
- wr_drop is asserted for exactly the cycle after the discarded request.
- clr_active is high for exactly NUM_REGS cycles, starting the cycle after the clr_req edge. The first normal write is accepted in the cycle clr_active falls.
- Reset asserted mid-sweep: immediate return to IDLE with all state cleared.

## Test plan
- Reset, then read addresses 0, 5, 31 -> all rd_data 0, all busy 0, clr_active 0.
- Single write reg7=0x3F800000 and read rd_addr1=7 in the same cycle -> with BYPASS=1, rd_data1=0x3F800000 that cycle. With BYPASS=0, the old value that cycle and the new value the next cycle.
- Pair write a=4, lo=0x11111111, hi=0x22222222 -> rd_data1=0x11111111 and rd_data1_hi=0x22222222 at rd_addr1=4. Pair write a=31 -> no change, wr_drop=1 the next cycle. Write a=0 with ZERO_PROT -> reg0 stays 0.
- bs_en, bs_dbl at addr 10 -> rd_busy1=1 and rd_busy1_hi=1 at rd_addr1=10. A later single write to 10 clears only busy[10]. A simultaneous bs_en and write to 12 leaves busy[12]=1.
- Fill regs 1..31 with nonzero values, pulse clr_req -> clr_active high 32 cycles. A write at sweep cycle 3 is dropped (wr_drop). All regs and busy bits are 0 afterward.
- Assert rst_n=0 mid-sweep at ptr=15 -> clr_active falls immediately and all registers read 0.

Source files
------------

// File: rtl/fp_reg_file_p_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_reg_file_p_if
// Description : Bundle of read, write, scoreboard and clear signals for the
//               FP register file.
//               master : issue/writeback side (drives addresses, write data,
//                        scoreboard sets, clear request)
//               slave  : the register file (drives read data, busy bits,
//                        clr_active, wr_drop)
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_reg_file_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] rd_data1_hi;
    logic [DATA_W-1:0] rd_data2_hi;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              rd_busy1_hi;
    logic              rd_busy2_hi;
    logic              wr_en;
    logic              wr_dbl;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data_lo;
    logic [DATA_W-1:0] wr_data_hi;
    logic              bs_en;
    logic              bs_dbl;
    logic [ADDR_W-1:0] bs_addr;
    logic              clr_req;
    logic              clr_active;
    logic              wr_drop;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_dbl, wr_addr, wr_data_lo,
               wr_data_hi, bs_en, bs_dbl, bs_addr, clr_req,
        input  rd_data1, rd_data2, rd_data1_hi, rd_data2_hi, rd_busy1,
               rd_busy2, rd_busy1_hi, rd_busy2_hi, clr_active, wr_drop
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_dbl, wr_addr, wr_data_lo,
               wr_data_hi, bs_en, bs_dbl, bs_addr, clr_req,
        output rd_data1, rd_data2, rd_data1_hi, rd_data2_hi, rd_busy1,
               rd_busy2, rd_busy1_hi, rd_busy2_hi, clr_active, wr_drop
    );
endinterface
`default_nettype wire

// File: rtl/fp_reg_file_p.sv
`default_nettype none
// ============================================================================
// Module      : fp_reg_file_p
// Description : FP register file with single/pair writes, two operand reads
//               (each with its pair-high word), same-cycle write bypass,
//               per-register pending-write scoreboard and a clear sweep.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - fp_reg_file_p_if.slave (reads, writes, scoreboard
//                       sets, clear request/status, wr_drop pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_reg_file_p #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit ZERO_PROT = 1'b1,
    parameter bit BYPASS    = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fp_reg_file_p_if.slave    bus
);
    localparam int                NUM_REGS    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ZERO_ADDR = '0;
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SWEEP = 1'b1;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [0:0]          r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_wr_drop;

    logic                w_sweep;
    logic [ADDR_W-1:0]   w_wr_addr_hi;
    logic [ADDR_W-1:0]   w_bs_addr_hi;
    logic                w_wr_pair_bad;
    logic                w_bs_pair_bad;
    logic                w_wr_ok;
    logic                w_bs_ok;
    logic                w_drop_req;
    logic [NUM_REGS-1:0] w_wr_lo_hit;
    logic [NUM_REGS-1:0] w_wr_hi_hit;
    logic [NUM_REGS-1:0] w_bs_hit;
    logic [ADDR_W-1:0]   w_rd_addr [4];
    logic [DATA_W-1:0]   w_rd_data [4];
    logic                w_rd_busy [4];

    assign w_sweep      = (r_state == c_ST_SWEEP);
    assign w_wr_addr_hi = bus.wr_addr + c_ONE;
    assign w_bs_addr_hi = bus.bs_addr + c_ONE;

    // A pair may neither wrap past the last register nor touch protected reg 0.
    assign w_wr_pair_bad = bus.wr_dbl &&
        ((bus.wr_addr == c_LAST_ADDR) || (ZERO_PROT && (bus.wr_addr == c_ZERO_ADDR)));
    assign w_bs_pair_bad = bus.bs_dbl &&
        ((bus.bs_addr == c_LAST_ADDR) || (ZERO_PROT && (bus.bs_addr == c_ZERO_ADDR)));

    // Single accesses to protected reg 0 are silently ignored (not a drop).
    assign w_wr_ok = bus.wr_en && !w_sweep && !w_wr_pair_bad &&
        !(ZERO_PROT && !bus.wr_dbl && (bus.wr_addr == c_ZERO_ADDR));
    assign w_bs_ok = bus.bs_en && !w_sweep && !w_bs_pair_bad &&
        !(ZERO_PROT && !bus.bs_dbl && (bus.bs_addr == c_ZERO_ADDR));

    assign w_drop_req = (bus.wr_en && (w_sweep || w_wr_pair_bad)) ||
                        (bus.bs_en && (w_sweep || w_bs_pair_bad));

    always_comb begin
        w_wr_lo_hit = '0;
        w_wr_hi_hit = '0;
        w_bs_hit    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_lo_hit[i] = w_wr_ok && (bus.wr_addr == ADDR_W'(i));
            w_wr_hi_hit[i] = w_wr_ok && bus.wr_dbl && (w_wr_addr_hi == ADDR_W'(i));
            w_bs_hit[i]    = w_bs_ok && ((bus.bs_addr == ADDR_W'(i)) ||
                                         (bus.bs_dbl && (w_bs_addr_hi == ADDR_W'(i))));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy    <= '0;
            r_state   <= c_ST_IDLE;
            r_ptr     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_drop_req;

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state <= c_ST_SWEEP;
                        r_ptr   <= '0;
                    end
                end
                c_ST_SWEEP: begin
                    r_ptr <= r_ptr + c_ONE;
                    if (r_ptr == c_LAST_ADDR) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase

            // Hit vectors are already gated off during the sweep, so the
            // sweep clear and normal updates never collide.
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_sweep && (r_ptr == ADDR_W'(i))) begin
                    r_regs[i] <= '0;
                    r_busy[i] <= 1'b0;
                end else begin
                    if (w_wr_lo_hit[i]) begin
                        r_regs[i] <= bus.wr_data_lo;
                    end else if (w_wr_hi_hit[i]) begin
                        r_regs[i] <= bus.wr_data_hi;
                    end
                    // Issue of a new producer outranks completion of the old one.
                    if (w_bs_hit[i]) begin
                        r_busy[i] <= 1'b1;
                    end else if (w_wr_lo_hit[i] || w_wr_hi_hit[i]) begin
                        r_busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read ports: 0 = op1 lo, 1 = op1 hi, 2 = op2 lo, 3 = op2 hi.
    // The hi address wraps naturally in ADDR_W bits.
    always_comb begin
        w_rd_addr[0] = bus.rd_addr1;
        w_rd_addr[1] = bus.rd_addr1 + c_ONE;
        w_rd_addr[2] = bus.rd_addr2;
        w_rd_addr[3] = bus.rd_addr2 + c_ONE;
        for (int p = 0; p < 4; p++) begin
            w_rd_data[p] = r_regs[w_rd_addr[p]];
            w_rd_busy[p] = r_busy[w_rd_addr[p]];
            if (BYPASS) begin
                if (w_wr_hi_hit[w_rd_addr[p]]) begin
                    w_rd_data[p] = bus.wr_data_hi;
                end else if (w_wr_lo_hit[w_rd_addr[p]]) begin
                    w_rd_data[p] = bus.wr_data_lo;
                end
                // Post-edge busy: the write clears it unless a set also lands.
                if (w_wr_hi_hit[w_rd_addr[p]] || w_wr_lo_hit[w_rd_addr[p]]) begin
                    w_rd_busy[p] = w_bs_hit[w_rd_addr[p]];
                end
            end
        end
    end

    assign bus.rd_data1    = w_rd_data[0];
    assign bus.rd_data1_hi = w_rd_data[1];
    assign bus.rd_data2    = w_rd_data[2];
    assign bus.rd_data2_hi = w_rd_data[3];
    assign bus.rd_busy1    = w_rd_busy[0];
    assign bus.rd_busy1_hi = w_rd_busy[1];
    assign bus.rd_busy2    = w_rd_busy[2];
    assign bus.rd_busy2_hi = w_rd_busy[3];
    assign bus.clr_active  = w_sweep;
    assign bus.wr_drop     = r_wr_drop;
endmodule
`default_nettype wire

// File: tb/tb_fp_reg_file_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_reg_file_p
// Description : Self-checking bench for fp_reg_file_p. Two instances share
//               the same stimulus: one with write bypass, one without. An
//               array-level model predicts both every cycle; directed
//               literal checks pin the model to hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_reg_file_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_reg_file_p_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    fp_reg_file_p_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

    assign bus2.rd_addr1   = bus1.rd_addr1;
    assign bus2.rd_addr2   = bus1.rd_addr2;
    assign bus2.wr_en      = bus1.wr_en;
    assign bus2.wr_dbl     = bus1.wr_dbl;
    assign bus2.wr_addr    = bus1.wr_addr;
    assign bus2.wr_data_lo = bus1.wr_data_lo;
    assign bus2.wr_data_hi = bus1.wr_data_hi;
    assign bus2.bs_en      = bus1.bs_en;
    assign bus2.bs_dbl     = bus1.bs_dbl;
    assign bus2.bs_addr    = bus1.bs_addr;
    assign bus2.clr_req    = bus1.clr_req;

    fp_reg_file_p #(.DATA_W(32), .ADDR_W(5), .ZERO_PROT(1'b1), .BYPASS(1'b1))
        u_dut_byp (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fp_reg_file_p #(.DATA_W(32), .ADDR_W(5), .ZERO_PROT(1'b1), .BYPASS(1'b0))
        u_dut_nob (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b0;

    // ---------------- model ----------------
    logic [31:0] m_reg  [32];
    bit          m_busy [32];
    bit          m_sweep = 1'b0;
    int          m_ptr   = 0;
    bit          m_drop  = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    end

    function automatic bit pair_bad(bit dbl, int a);
        return dbl && (a == 31 || a == 0);
    endfunction

    function automatic bit wr_takes();
        int a = int'(bus1.wr_addr);
        return bus1.wr_en && !m_sweep && !pair_bad(bus1.wr_dbl, a) && !(!bus1.wr_dbl && a == 0);
    endfunction

    function automatic bit bs_takes();
        int a = int'(bus1.bs_addr);
        return bus1.bs_en && !m_sweep && !pair_bad(bus1.bs_dbl, a) && !(!bus1.bs_dbl && a == 0);
    endfunction

    function automatic bit wr_covers(int r);
        int a = int'(bus1.wr_addr);
        return wr_takes() && (r == a || (bus1.wr_dbl && r == a + 1));
    endfunction

    function automatic bit bs_covers(int r);
        int a = int'(bus1.bs_addr);
        return bs_takes() && (r == a || (bus1.bs_dbl && r == a + 1));
    endfunction

    function automatic logic [31:0] exp_data(int r, bit byp);
        int a = int'(bus1.wr_addr);
        if (byp && wr_takes()) begin
            if (r == a) return bus1.wr_data_lo;
            if (bus1.wr_dbl && r == a + 1) return bus1.wr_data_hi;
        end
        return m_reg[r];
    endfunction

    function automatic logic [31:0] exp_busy(int r, bit byp);
        if (byp && wr_covers(r)) return {31'b0, bs_covers(r)};
        return {31'b0, m_busy[r]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_sweep = 1'b0;
            m_ptr   = 0;
            m_drop  = 1'b0;
        end else begin
            bit drop;
            drop = 1'b0;
            if (m_sweep) begin
                m_reg[m_ptr]  = 32'h0;
                m_busy[m_ptr] = 1'b0;
                if (bus1.wr_en || bus1.bs_en) drop = 1'b1;
                if (m_ptr == 31) m_sweep = 1'b0;
                else m_ptr = m_ptr + 1;
            end else begin
                if (bus1.wr_en && pair_bad(bus1.wr_dbl, int'(bus1.wr_addr))) drop = 1'b1;
                if (bus1.bs_en && pair_bad(bus1.bs_dbl, int'(bus1.bs_addr))) drop = 1'b1;
                for (int r = 0; r < 32; r++) begin
                    if (wr_covers(r)) begin
                        m_reg[r]  = exp_data(r, 1'b1);
                        m_busy[r] = 1'b0;
                    end
                    if (bs_covers(r)) m_busy[r] = 1'b1;
                end
                if (bus1.clr_req) begin
                    m_sweep = 1'b1;
                    m_ptr   = 0;
                end
            end
            m_drop = drop;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            int a1, a1h, a2, a2h;
            a1  = int'(bus1.rd_addr1);
            a1h = (a1 + 1) % 32;
            a2  = int'(bus1.rd_addr2);
            a2h = (a2 + 1) % 32;
            chk("byp rd_data1",    bus1.rd_data1,    exp_data(a1, 1'b1));
            chk("byp rd_data1_hi", bus1.rd_data1_hi, exp_data(a1h, 1'b1));
            chk("byp rd_data2",    bus1.rd_data2,    exp_data(a2, 1'b1));
            chk("byp rd_data2_hi", bus1.rd_data2_hi, exp_data(a2h, 1'b1));
            chk("byp rd_busy1",    {31'b0, bus1.rd_busy1},    exp_busy(a1, 1'b1));
            chk("byp rd_busy1_hi", {31'b0, bus1.rd_busy1_hi}, exp_busy(a1h, 1'b1));
            chk("byp rd_busy2",    {31'b0, bus1.rd_busy2},    exp_busy(a2, 1'b1));
            chk("byp rd_busy2_hi", {31'b0, bus1.rd_busy2_hi}, exp_busy(a2h, 1'b1));
            chk("nob rd_data1",    bus2.rd_data1,    exp_data(a1, 1'b0));
            chk("nob rd_data1_hi", bus2.rd_data1_hi, exp_data(a1h, 1'b0));
            chk("nob rd_data2",    bus2.rd_data2,    exp_data(a2, 1'b0));
            chk("nob rd_data2_hi", bus2.rd_data2_hi, exp_data(a2h, 1'b0));
            chk("nob rd_busy1",    {31'b0, bus2.rd_busy1},    exp_busy(a1, 1'b0));
            chk("nob rd_busy1_hi", {31'b0, bus2.rd_busy1_hi}, exp_busy(a1h, 1'b0));
            chk("nob rd_busy2",    {31'b0, bus2.rd_busy2},    exp_busy(a2, 1'b0));
            chk("nob rd_busy2_hi", {31'b0, bus2.rd_busy2_hi}, exp_busy(a2h, 1'b0));
            chk("byp clr_active",  {31'b0, bus1.clr_active}, {31'b0, m_sweep});
            chk("nob clr_active",  {31'b0, bus2.clr_active}, {31'b0, m_sweep});
            chk("byp wr_drop",     {31'b0, bus1.wr_drop},    {31'b0, m_drop});
            chk("nob wr_drop",     {31'b0, bus2.wr_drop},    {31'b0, m_drop});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus1.wr_en   = 1'b0;
        bus1.wr_dbl  = 1'b0;
        bus1.bs_en   = 1'b0;
        bus1.bs_dbl  = 1'b0;
        bus1.clr_req = 1'b0;
    endtask

    task automatic set_wr(input int a, input bit dbl, input logic [31:0] lo, input logic [31:0] hi);
        bus1.wr_en      = 1'b1;
        bus1.wr_dbl     = dbl;
        bus1.wr_addr    = 5'(a);
        bus1.wr_data_lo = lo;
        bus1.wr_data_hi = hi;
    endtask

    task automatic set_bs(input int a, input bit dbl);
        bus1.bs_en   = 1'b1;
        bus1.bs_dbl  = dbl;
        bus1.bs_addr = 5'(a);
    endtask

    initial begin
        int n;
        quiet();
        bus1.rd_addr1   = '0;
        bus1.rd_addr2   = '0;
        bus1.wr_addr    = '0;
        bus1.bs_addr    = '0;
        bus1.wr_data_lo = '0;
        bus1.wr_data_hi = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // reset state
        bus1.rd_addr1 = 5'd0;
        bus1.rd_addr2 = 5'd5;
        #2;
        chk("rst rd_data1",    bus1.rd_data1, 32'h0);
        chk("rst rd_data2_hi", bus1.rd_data2_hi, 32'h0);
        chk("rst rd_busy2",    {31'b0, bus1.rd_busy2}, 32'h0);
        chk("rst clr_active",  {31'b0, bus1.clr_active}, 32'h0);
        step();
        bus1.rd_addr1 = 5'd31;
        #2;
        chk("rst wrap hi", bus1.rd_data1_hi, 32'h0);

        // same-cycle bypass vs registered read
        step();
        bus1.rd_addr1 = 5'd7;
        set_wr(7, 1'b0, 32'h3F800000, 32'h0);
        #2;
        chk("lit byp same cycle", bus1.rd_data1, 32'h3F800000);
        chk("lit nob old value",  bus2.rd_data1, 32'h0);
        step();
        quiet();
        #2;
        chk("lit nob next cycle", bus2.rd_data1, 32'h3F800000);

        // legal pair at 4
        step();
        set_wr(4, 1'b1, 32'h11111111, 32'h22222222);
        bus1.rd_addr1 = 5'd4;
        step();
        quiet();
        #2;
        chk("lit pair lo", bus2.rd_data1,    32'h11111111);
        chk("lit pair hi", bus2.rd_data1_hi, 32'h22222222);

        // illegal pair at 31
        step();
        set_wr(31, 1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB);
        bus1.rd_addr1 = 5'd31;
        step();
        quiet();
        #2;
        chk("lit pair31 drop", {31'b0, bus1.wr_drop}, 32'h1);
        chk("lit pair31 lo",   bus1.rd_data1,    32'h0);
        chk("lit pair31 hi",   bus1.rd_data1_hi, 32'h0);

        // single write to protected reg 0
        step();
        set_wr(0, 1'b0, 32'hDEADBEEF, 32'h0);
        bus1.rd_addr1 = 5'd0;
        #2;
        chk("lit reg0 no bypass", bus1.rd_data1, 32'h0);
        step();
        quiet();
        #2;
        chk("lit reg0 stays 0", bus1.rd_data1, 32'h0);

        // scoreboard pair set at 10, then completion of 10 only
        step();
        set_bs(10, 1'b1);
        bus1.rd_addr1 = 5'd10;
        step();
        quiet();
        #2;
        chk("lit busy10", {31'b0, bus1.rd_busy1},    32'h1);
        chk("lit busy11", {31'b0, bus1.rd_busy1_hi}, 32'h1);
        step();
        set_wr(10, 1'b0, 32'h12345678, 32'h0);
        #2;
        chk("lit byp busy10 clear", {31'b0, bus1.rd_busy1}, 32'h0);
        chk("lit nob busy10 old",   {31'b0, bus2.rd_busy1}, 32'h1);
        step();
        quiet();
        #2;
        chk("lit busy10 after", {31'b0, bus2.rd_busy1},    32'h0);
        chk("lit busy11 after", {31'b0, bus2.rd_busy1_hi}, 32'h1);

        // set and clear of reg 12 in one cycle: set wins
        step();
        set_wr(12, 1'b0, 32'hCAFEF00D, 32'h0);
        set_bs(12, 1'b0);
        bus1.rd_addr2 = 5'd12;
        #2;
        chk("lit byp busy12", {31'b0, bus1.rd_busy2}, 32'h1);
        chk("lit byp data12", bus1.rd_data2, 32'hCAFEF00D);
        step();
        quiet();
        #2;
        chk("lit busy12 kept", {31'b0, bus2.rd_busy2}, 32'h1);

        // legal pair at 30 with an illegal scoreboard pair at 0
        step();
        set_wr(30, 1'b1, 32'h30303030, 32'h31313131);
        set_bs(0, 1'b1);
        bus1.rd_addr1 = 5'd30;
        bus1.rd_addr2 = 5'd31;
        step();
        quiet();
        #2;
        chk("lit reg31",      bus1.rd_data2,    32'h31313131);
        chk("lit reg31 wrap", bus1.rd_data2_hi, 32'h0);
        chk("lit bs0 drop",   {31'b0, bus1.wr_drop}, 32'h1);
        step();
        set_bs(31, 1'b1);
        step();
        quiet();

        // fill 1..31 and mark some busy
        for (int i = 1; i < 32; i++) begin
            set_wr(i, 1'b0, 32'(i) * 32'h01010101, 32'h0);
            bus1.rd_addr1 = 5'(i);
            bus1.rd_addr2 = 5'((i + 16) % 32);
            step();
        end
        quiet();
        set_bs(20, 1'b1);
        step();
        set_bs(3, 1'b0);
        step();
        quiet();

        // clear sweep with a write in sweep cycle 3 and an ignored clr_req
        bus1.clr_req = 1'b1;
        step();
        bus1.clr_req = 1'b0;
        n = 0;
        while (bus1.clr_active && n < 100) begin
            quiet();
            if (n == 3) set_wr(9, 1'b0, 32'h00000099, 32'h0);
            if (n == 5) bus1.clr_req = 1'b1;
            bus1.rd_addr1 = 5'(n);
            step();
            n++;
        end
        quiet();
        chk("lit clr_active cycles", 32'(n), 32'd32);
        set_wr(9, 1'b0, 32'h5A5A5A5A, 32'h0);
        bus1.rd_addr1 = 5'd9;
        #2;
        chk("lit first write after sweep", bus1.rd_data1, 32'h5A5A5A5A);
        step();
        quiet();
        for (int i = 0; i < 32; i++) begin
            bus1.rd_addr1 = 5'(i);
            bus1.rd_addr2 = 5'((i + 16) % 32);
            step();
        end
        bus1.rd_addr1 = 5'd20;
        #2;
        chk("lit reg20 swept",  bus1.rd_data1, 32'h0);
        chk("lit busy20 swept", {31'b0, bus1.rd_busy1}, 32'h0);

        // reset in the middle of a sweep at ptr 15
        step();
        set_wr(20, 1'b0, 32'h00000077, 32'h0);
        step();
        quiet();
        bus1.clr_req = 1'b1;
        step();
        bus1.clr_req = 1'b0;
        repeat (15) step();
        #2;
        chk("lit reg20 before rst", bus1.rd_data1, 32'h00000077);
        rst_n = 1'b0;
        #1;
        chk("lit rst clr_active", {31'b0, bus1.clr_active}, 32'h0);
        chk("lit rst reg20",      bus1.rd_data1, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, limit 200000 time units");
        $fatal(1);
    end
endmodule
`default_nettype wire
